// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits, frame settings latched at each pop.
module uart_tx_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW = 2
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] uart_ctrl,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tx_baud,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tx_data,
    input  logic                          tx_data_wr,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_fifo_empty,
    output logic                          tx_fifo_full,
    output logic [FIFO_AW:0]              tx_fifo_level,
    output logic                          tx_done,
    output logic                          tx_ovf
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d, div_q, div_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d, par_q, par_d, stop2_q, stop2_d;
    logic                 txd_q, txd_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic                 empty_q, empty_d, full_q, full_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [FIFO_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           head;
    logic                 tx_en, bit_end, frame_end, pop, push, unused_bits;

    assign unused_bits = ^{uart_ctrl[C_S_AXI_DATA_WIDTH-1:4], tx_baud[C_S_AXI_DATA_WIDTH-1:16],
                           tx_data[C_S_AXI_DATA_WIDTH-1:8]};
    assign tx_en     = uart_ctrl[0];
    assign head      = mem_q[rptr_q];
    assign bit_end   = (state_q != IDLE) && (cnt_q == 16'd0);
    assign frame_end = (state_q == STOP) && bit_end && !stop2_q;
    // A pop at frame end frees a slot, so a write on that same edge is accepted.
    assign pop       = tx_en && (level_q != '0) && ((state_q == IDLE) || frame_end);
    assign push      = tx_data_wr && ((level_q != DEPTH) || pop);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == IDLE) ? cnt_q : (bit_end ? div_q : cnt_q - 16'd1);
        div_d      = div_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        done_d     = frame_end;
        ovf_d      = tx_data_wr && (level_q == DEPTH) && !pop;
        if (pop) begin
            state_d    = START;
            div_d      = tx_baud[15:0];
            cnt_d      = tx_baud[15:0];
            par_en_d   = uart_ctrl[1];
            par_odd_d  = uart_ctrl[2];
            two_stop_d = uart_ctrl[3];
            shift_d    = head;
            par_d      = ^head;
            txd_d      = 1'b0;
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    idx_d   = 3'd0;
                end
                DATA: begin
                    if (idx_q == 3'd7) begin
                        state_d = par_en_q ? PARITY : STOP;
                        txd_d   = par_en_q ? (par_q ^ par_odd_q) : 1'b1;
                        stop2_d = two_stop_q;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    stop2_d = two_stop_q;
                end
                STOP: begin
                    stop2_d = 1'b0;
                    state_d = stop2_q ? STOP : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        level_d = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        wptr_d  = wptr_q + FIFO_AW'(push);
        rptr_d  = rptr_q + FIFO_AW'(pop);
        busy_d  = state_d != IDLE;
        empty_d = level_d == '0;
        full_d  = level_d == DEPTH;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) mem_q[wptr_q] <= tx_data[7:0];
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            level_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            level_q    <= level_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    assign uart_txd      = txd_q;
    assign tx_busy       = busy_q;
    assign tx_fifo_empty = empty_q;
    assign tx_fifo_full  = full_q;
    assign tx_fifo_level = level_q;
    assign tx_done       = done_q;
    assign tx_ovf        = ovf_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed checks of framing, parity, stop bits, FIFO and reset.
module tb_uart_tx_engine;
    logic        clk, rst;
    logic [31:0] uart_ctrl, tx_baud, tx_data;
    logic        tx_data_wr;
    logic        txd, busy, empty, full, done, ovf;
    logic [2:0]  level;
    logic [39:0] stream;
    int          errors = 0;
    int          checks = 0;

    uart_tx_engine dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .uart_ctrl(uart_ctrl), .tx_baud(tx_baud),
        .tx_data(tx_data), .tx_data_wr(tx_data_wr), .uart_txd(txd), .tx_busy(busy),
        .tx_fifo_empty(empty), .tx_fifo_full(full), .tx_fifo_level(level),
        .tx_done(done), .tx_ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] b);
        tx_data = {24'd0, b};
        tx_data_wr = 1'b1;
        step(1);
        tx_data_wr = 1'b0;
    endtask

    // pat holds the expected line bits in transmit order, bit 0 first.
    task automatic send_frame(input logic [7:0] b, input logic [15:0] pat, input int nbits, input int per);
        write(b);
        chk1("txd_before_start", txd, 1'b1);
        step(1);
        chk1("busy_start", busy, 1'b1);
        for (int i = 0; i < nbits * per; i++) begin
            chk1("frame_bit", txd, pat[i / per]);
            chk1("done_low", done, 1'b0);
            step(1);
        end
        chk1("done_pulse", done, 1'b1);
        chk1("busy_after", busy, 1'b0);
        chk1("txd_idle_after", txd, 1'b1);
        step(1);
        chk1("done_clear", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        uart_ctrl = '0;
        tx_baud = '0;
        tx_data = '0;
        tx_data_wr = 1'b0;
        step(2);
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_full", full, 1'b0);
        chkl("rst_level", level, 3'd0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        uart_ctrl = 32'h1;
        tx_baud = 32'd3;
        send_frame(8'h55, {6'd0, 1'b1, 8'h55, 1'b0}, 10, 4);

        uart_ctrl = 32'h3;
        tx_baud = 32'd0;
        send_frame(8'h07, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1);

        uart_ctrl = 32'hF;
        send_frame(8'h07, {4'd0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 1);

        uart_ctrl = 32'h0;
        for (int k = 0; k < 4; k++) write(8'h10 + 8'(k));
        chkl("fill_level", level, 3'd4);
        chk1("fill_full", full, 1'b1);
        chk1("fill_empty", empty, 1'b0);
        chk1("fill_no_ovf", ovf, 1'b0);
        write(8'h14);
        chk1("ovf_pulse", ovf, 1'b1);
        chkl("ovf_level", level, 3'd4);
        step(1);
        chk1("ovf_clear", ovf, 1'b0);
        uart_ctrl = 32'h1;
        step(1);
        chkl("b2b_first_pop", level, 3'd3);
        stream = {1'b1, 8'h13, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h10, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk1("b2b_bit", txd, stream[i]);
            chk1("b2b_done", done, (i > 0) && (i % 10 == 0));
            step(1);
        end
        chk1("b2b_done_end", done, 1'b1);
        chk1("b2b_busy_end", busy, 1'b0);
        chk1("b2b_empty_end", empty, 1'b1);
        chkl("b2b_level_end", level, 3'd0);

        tx_baud = 32'd3;
        write(8'hA5);
        write(8'h3C);
        chkl("mid_level", level, 3'd1);
        step(8);
        chk1("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("arst_txd", txd, 1'b1);
        chkl("arst_level", level, 3'd0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_empty", empty, 1'b1);
        step(1);
        rst = 1'b0;
        tx_baud = 32'd0;
        send_frame(8'h5A, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 1);

        uart_ctrl = 32'h0;
        for (int k = 0; k < 4; k++) write(8'h20 + 8'(k));
        uart_ctrl = 32'h1;
        step(1);
        chkl("pp_after_pop", level, 3'd3);
        write(8'h24);
        chkl("pp_refull", level, 3'd4);
        step(8);
        chk1("pp_pre_done", done, 1'b0);
        tx_data = 32'h25;
        tx_data_wr = 1'b1;
        step(1);
        tx_data_wr = 1'b0;
        chk1("pp_done", done, 1'b1);
        chkl("pp_level", level, 3'd4);
        chk1("pp_full", full, 1'b1);
        chk1("pp_no_ovf", ovf, 1'b0);
        chk1("pp_next_start", txd, 1'b0);
        step(1);
        chk1("pp_no_ovf_late", ovf, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmitter directly downstream of the AXI-Lite register block.
- Consumes the uart_ctrl, tx_baud and tx_data registers plus a write strobe for tx_data.
- Buffers bytes in a small FIFO and serialises them onto uart_txd: LSB first, 8 data bits, optional parity, 1 or 2 stop bits.
- Status outputs feed back to the register block for readback.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of the register inputs; only the low bits listed below are used.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  reset; asynchronous assert, active-high.
- uart_ctrl  in  C_S_AXI_DATA_WIDTH  bit0 tx_en, bit1 parity_en, bit2 parity_odd (1 = odd), bit3 two_stop; other bits ignored.
- tx_baud  in  C_S_AXI_DATA_WIDTH  bits[15:0] = divisor; bit period is divisor+1 clocks.
- tx_data  in  C_S_AXI_DATA_WIDTH  bits[7:0] = byte to send.
- tx_data_wr  in  1  one-cycle strobe: tx_data was just written.
- uart_txd  out  1  serial line; idle high.
- tx_busy  out  1  FSM not in IDLE.
- tx_fifo_empty  out  1  FIFO holds 0 entries.
- tx_fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- tx_fifo_level  out  FIFO_AW+1  current entry count.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- tx_ovf  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset state (asynchronous, active-high): uart_txd=1, tx_busy=0, tx_fifo_empty=1, tx_fifo_full=0, tx_fifo_level=0, tx_done=0, tx_ovf=0, FSM=IDLE, FIFO pointers=0, baud counter=0.
- Reset mid-frame: the frame is abandoned, uart_txd returns high immediately, and FIFO contents are discarded.
- FIFO write:
  - On a clock edge with tx_data_wr=1 and (not full, or a pop occurs in the same cycle), tx_data[7:0] is written.
  - tx_data_wr=1 while full with no pop: the byte is dropped, FIFO is unchanged, and tx_ovf pulses on the next cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the level counter saturates at 0..FIFO_DEPTH by construction.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - If tx_en=1 and FIFO not empty, at the edge: pop the head into shift_reg[7:0], latch divisor, parity_en, parity_odd and two_stop for the whole frame, drive uart_txd=0, load the baud counter with the divisor, go to START.
  - If tx_en=0, stay in IDLE; the FIFO still accepts writes.
- Bit timing:
  - Each bit holds uart_txd for exactly divisor+1 clocks.
  - The counter decrements each clock; the bit ends at the edge where the counter=0, which reloads it with the latched divisor.
  - divisor=0 gives 1 clock per bit.
- START end: drive shift_reg[0], bit index=0, go to DATA.
- DATA: at each bit end, shift right and drive the next bit. After bit 7:
  - go to PARITY if parity_en; uart_txd = XOR of the data, inverted if parity_odd;
  - otherwise go to STOP with uart_txd=1.
- PARITY end: go to STOP, uart_txd=1.
- STOP:
  - Lasts 1 bit period, or 2 if two_stop.
  - At its end, tx_done pulses for 1 cycle.
  - If tx_en=1 and FIFO not empty: pop, go straight to START with uart_txd=0 (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency: tx_data_wr sampled at edge k (FIFO empty, FSM IDLE, tx_en=1) → uart_txd falls at edge k+1.
- Register changes mid-frame (uart_ctrl bits 1-3, tx_baud): take effect from the next frame.
- tx_en cleared mid-frame: the current frame completes, then the FSM holds in IDLE.
- tx_busy = (state != IDLE).
- Widths: the baud counter is 16 bits; no arithmetic overflow is possible.

Test Plan:
- Reset, then tx_baud=3, uart_ctrl=0x1, write 0x55 → uart_txd low 1 cycle after the write edge; bit pattern 0,1,0,1,0,1,0,1,0,1, each 4 clocks; tx_done pulses 40 clocks after the start edge; tx_busy=0 afterwards.
- uart_ctrl=0x3 (even parity), tx_baud=0, write 0x07 → 11 one-clock bits; parity bit=1; then stop.
- uart_ctrl=0x7 (odd parity) plus bit3 (two stop), write 0x07 → parity bit=0; stop high for 2 bit periods before tx_done.
- uart_ctrl=0 (tx_en off), 5 writes 0x10..0x14 → level 4, full=1, tx_ovf pulse on the 5th write; then set tx_en → 0x10..0x13 sent back-to-back with no idle gap; empty=1 at the end.
- Assert S_AXI_ARESET mid-DATA → uart_txd=1, level=0 and busy=0 immediately; after release a new write transmits correctly.
- Full FIFO during STOP end with a simultaneous write → pop and push both occur; level stays 4 and no tx_ovf.
